// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: instruction/data memory request-ready handshake bundle
interface multicycle_sequencer_if #(parameter int XLEN = 64) ();
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ready;
  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready
  );
  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: PC/IR owner and FETCH-DECODE-EXECUTE-MEM-WB control FSM with wait-state tolerant memory handshakes
module multicycle_sequencer #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  multicycle_sequencer_if.master mem,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  output logic [XLEN-1:0]        pc,
  output logic [31:0]            ir,
  output logic                   reg_we,
  output logic                   mem_to_reg,
  output logic                   retire,
  output logic [2:0]             state,
  output logic                   trap,
  output logic [1:0]             trap_cause
);
  localparam int            CW   = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] WMAX = CW'(TIMEOUT - 1);
  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXECUTE = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    TRAP    = 3'd7
  } state_t;
  state_t          st, st_n;
  logic [XLEN-1:0] pc_n, pc_inc;
  logic [31:0]     ir_n;
  logic [1:0]      cause_n;
  logic [CW-1:0]   wcnt, wcnt_n;
  logic            is_alu, is_ld, is_st, is_br, legal, br_bad, rdy;
  assign pc_inc = pc + XLEN'(4);
  assign is_alu = ir[6:0] == 7'b0110011 || ir[6:0] == 7'b0010011;
  assign is_ld  = ir[6:0] == 7'b0000011;
  assign is_st  = ir[6:0] == 7'b0100011;
  assign is_br  = ir[6:0] == 7'b1100011;
  assign legal  = is_alu || is_ld || is_st || is_br;
  assign br_bad = branch_taken && branch_target[1:0] != 2'b00;
  assign rdy    = st == FETCH ? mem.imem_ready : mem.dmem_ready;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st         <= FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      trap_cause <= '0;
      wcnt       <= '0;
    end else begin
      st         <= st_n;
      pc         <= pc_n;
      ir         <= ir_n;
      trap_cause <= cause_n;
      wcnt       <= wcnt_n;
    end
  // wcnt_n defaults to 0 so every state change clears the wait counter
  always_comb begin
    st_n    = st;
    pc_n    = pc;
    ir_n    = ir;
    cause_n = trap_cause;
    wcnt_n  = '0;
    case (st)
      FETCH, MEM:
        if (rdy) begin
          st_n = st == FETCH ? DECODE : (is_st ? FETCH : WB);
          ir_n = st == FETCH ? mem.imem_rdata : ir;
          pc_n = st == MEM && is_st ? pc_inc : pc;
        end else if (wcnt == WMAX) begin
          st_n    = TRAP;
          cause_n = 2'd1;
        end else begin
          wcnt_n = wcnt + CW'(1);
        end
      DECODE: begin
        st_n    = legal ? EXECUTE : TRAP;
        cause_n = legal ? trap_cause : 2'd2;
      end
      EXECUTE:
        if (is_br) begin
          st_n    = br_bad ? TRAP : FETCH;
          cause_n = br_bad ? 2'd3 : trap_cause;
          pc_n    = br_bad ? pc : (branch_taken ? branch_target : pc_inc);
        end else begin
          st_n = is_ld || is_st ? MEM : WB;
        end
      WB: begin
        st_n = FETCH;
        pc_n = pc_inc;
      end
      default: st_n = TRAP;
    endcase
  end
  // every strobe is gated by reset so an asserted reset kills them without waiting for a clock
  assign state         = st;
  assign trap          = st == TRAP;
  assign mem.imem_addr = pc;
  assign mem.imem_req  = reset && st == FETCH;
  assign mem.dmem_req  = reset && st == MEM;
  assign mem.dmem_we   = reset && st == MEM && is_st;
  assign reg_we        = reset && st == WB;
  assign mem_to_reg    = reset && st == WB && is_ld;
  assign retire        = reset && (st == WB || (st == EXECUTE && is_br && !br_bad) ||
                                   (st == MEM && is_st && mem.dmem_ready));
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed instructions with a retire/trap scoreboard checked by an independent monitor
module tb_multicycle_sequencer;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_FFFF_FFFC;
  typedef struct {
    string       name;
    bit          kind;
    logic [2:0]  st;
    logic        rw, m2r, we;
    logic [63:0] pc;
    logic [1:0]  cause;
    int          lat, dreq;
    logic [31:0] ins;
  } exp_t;
  logic        clk = 0, rst_n = 0;
  logic        branch_taken = 0;
  logic [63:0] branch_target = '0;
  logic [63:0] pc;
  logic [31:0] ir;
  logic        reg_we, mem_to_reg, retire, trap;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  int          errors = 0, checks = 0;
  int          iw_cfg = 0, dw_cfg = 0;
  logic [31:0] ins_cfg = '0;
  exp_t        q[$];
  exp_t        e;
  int          cyc = 0, start = 0, dcnt = 0, ev = 0;
  logic [2:0]  prev_st = 3'd7;
  bit          pend = 0, trap_prev = 0;
  logic [63:0] pend_pc = '0;
  multicycle_sequencer_if #(.XLEN(64)) bus ();
  multicycle_sequencer #(.XLEN(64), .RESET_PC(RPC), .TIMEOUT(16)) dut (
    .clk(clk), .reset(rst_n), .mem(bus),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .pc(pc), .ir(ir), .reg_we(reg_we), .mem_to_reg(mem_to_reg), .retire(retire),
    .state(state), .trap(trap), .trap_cause(trap_cause)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic exp_t mk(input string n, input bit k, input logic [2:0] s, input logic rw, input logic m2r,
                              input logic we, input logic [63:0] p, input logic [1:0] c, input int l, input int d);
    exp_t r;
    r.name = n; r.kind = k; r.st = s; r.rw = rw; r.m2r = m2r; r.we = we;
    r.pc = p; r.cause = c; r.lat = l; r.dreq = d; r.ins = '0;
    return r;
  endfunction
  // memories: ready after a configurable number of wait cycles, driven between clock edges
  initial begin
    int icnt, dcn;
    icnt = 0; dcn = 0;
    bus.imem_ready = 0; bus.dmem_ready = 0; bus.imem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      bus.imem_rdata = ins_cfg;
      if (bus.imem_req) begin bus.imem_ready = icnt >= iw_cfg; icnt++; end
      else begin bus.imem_ready = 0; icnt = 0; end
      if (bus.dmem_req) begin bus.dmem_ready = dcn >= dw_cfg; dcn++; end
      else begin bus.dmem_ready = 0; dcn = 0; end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_st = 3'd7; pend = 0; trap_prev = 0;
    end else begin
      cyc++;
      if (pend) begin chk("pc_after_retire", pc, pend_pc); pend = 0; end
      if (state == 3'd0 && prev_st != 3'd0) begin start = cyc; dcnt = 0; end
      if (bus.dmem_req) begin
        dcnt++;
        if (q.size() > 0) chk({q[0].name, "_dmem_we"}, 64'(bus.dmem_we), 64'(q[0].we));
      end
      if (reg_we) chk("reg_we_only_with_retire", 64'(retire), 64'd1);
      if (retire || (trap && !trap_prev)) begin
        ev++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: retire=%0b trap=%0b with no expectation queued", retire, trap);
        end else begin
          e = q.pop_front();
          chk({e.name, "_kind"}, 64'(trap), 64'(e.kind));
          chk({e.name, "_ir"}, 64'(ir), 64'(e.ins));
          chk({e.name, "_latency"}, 64'(trap ? cyc - start : cyc - start + 1), 64'(e.lat));
          chk({e.name, "_dmem_req_cycles"}, 64'(dcnt), 64'(e.dreq));
          if (trap) begin
            chk({e.name, "_state"}, 64'(state), 64'd7);
            chk({e.name, "_cause"}, 64'(trap_cause), 64'(e.cause));
            chk({e.name, "_pc_frozen"}, pc, e.pc);
            chk({e.name, "_reqs_low"}, 64'({bus.imem_req, bus.dmem_req}), 64'd0);
          end else begin
            chk({e.name, "_state"}, 64'(state), 64'(e.st));
            chk({e.name, "_reg_we"}, 64'(reg_we), 64'(e.rw));
            chk({e.name, "_mem_to_reg"}, 64'(mem_to_reg), 64'(e.m2r));
            pend = 1; pend_pc = e.pc;
          end
        end
      end
      trap_prev = trap; prev_st = state;
    end
  end
  task automatic run(input logic [31:0] ins, input int iw, input int dw, input logic tk,
                     input logic [63:0] tg, input exp_t x);
    int e0;
    ins_cfg = ins; iw_cfg = iw; dw_cfg = dw; branch_taken = tk; branch_target = tg;
    x.ins = ins;
    q.push_back(x);
    e0 = ev;
    for (int i = 0; i < 300 && ev == e0; i++) @(posedge clk);
    #1;
    if (ev == e0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no retire or trap within 300 cycles", x.name);
    end
  endtask
  task automatic reset_checks();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_pc", pc, RPC);
    chk("rst_ir", 64'(ir), 64'd0);
    chk("rst_trap", 64'({trap, trap_cause}), 64'd0);
    chk("rst_mem_strobes", 64'({bus.imem_req, bus.dmem_req, bus.dmem_we}), 64'd0);
    chk("rst_strobes", 64'({reg_we, mem_to_reg, retire}), 64'd0);
  endtask
  task automatic do_reset();
    @(negedge clk); #1 rst_n = 0; #1;
    reset_checks();
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
  endtask
  task automatic hold_trap(input logic [63:0] p, input logic [1:0] c);
    repeat (20) @(posedge clk);
    #1;
    chk("hold_state", 64'(state), 64'd7);
    chk("hold_trap", 64'(trap), 64'd1);
    chk("hold_cause", 64'(trap_cause), 64'(c));
    chk("hold_pc", pc, p);
    chk("hold_strobes", 64'({bus.imem_req, bus.dmem_req, reg_we, retire}), 64'd0);
  endtask
  initial begin
    do_reset();
    run(32'h00500093, 0, 0, 0, 64'h0, mk("addi_wrap", 0, 3'd4, 1, 0, 0, 64'h0, 2'd0, 4, 0));
    run(32'h0000B103, 0, 3, 0, 64'h0, mk("load_wait3", 0, 3'd4, 1, 1, 0, 64'h4, 2'd0, 8, 4));
    run(32'h00113023, 0, 1, 0, 64'h0, mk("store_wait1", 0, 3'd3, 0, 0, 1, 64'h8, 2'd0, 5, 2));
    run(32'h002081B3, 2, 0, 0, 64'h0, mk("add_iwait2", 0, 3'd4, 1, 0, 0, 64'hC, 2'd0, 6, 0));
    run(32'h00208463, 0, 0, 1, 64'h100, mk("br_taken", 0, 3'd2, 0, 0, 0, 64'h100, 2'd0, 3, 0));
    run(32'h00208463, 0, 0, 0, 64'h200, mk("br_not_taken", 0, 3'd2, 0, 0, 0, 64'h104, 2'd0, 3, 0));
    run(32'h00500093, 15, 0, 0, 64'h0, mk("ready_last_cycle", 0, 3'd4, 1, 0, 0, 64'h108, 2'd0, 19, 0));
    run(32'h00208463, 0, 0, 1, 64'h102, mk("br_misaligned", 1, 3'd7, 0, 0, 0, 64'h108, 2'd3, 3, 0));
    hold_trap(64'h108, 2'd3);
    do_reset();
    run(32'h00500093, 0, 0, 0, 64'h0, mk("addi_wrap2", 0, 3'd4, 1, 0, 0, 64'h0, 2'd0, 4, 0));
    run(32'h00500093, 1000, 0, 0, 64'h0, mk("fetch_timeout", 1, 3'd7, 0, 0, 0, 64'h0, 2'd1, 16, 0));
    do_reset();
    run(32'hFFFFFFFF, 0, 0, 0, 64'h0, mk("illegal", 1, 3'd7, 0, 0, 0, RPC, 2'd2, 2, 0));
    hold_trap(RPC, 2'd2);
    do_reset();
    ins_cfg = 32'h00113023; iw_cfg = 0; dw_cfg = 1000;
    for (int i = 0; i < 20 && state != 3'd3; i++) begin @(posedge clk); #1; end
    chk("abort_reached_mem", 64'(state), 64'd3);
    @(posedge clk); #1;
    chk("abort_dmem_req_high", 64'({bus.dmem_req, bus.dmem_we}), 64'd3);
    @(negedge clk); #1 rst_n = 0; #1;
    chk("abort_dmem_req_drop", 64'({bus.dmem_req, bus.dmem_we, retire}), 64'd0);
    reset_checks();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    run(32'h00500093, 0, 0, 0, 64'h0, mk("addi_after_abort", 0, 3'd4, 1, 0, 0, 64'h0, 2'd0, 4, 0));
    @(negedge clk); #1;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
